// File: rtl/rc5_enc_16bit_core.sv
// One-round RC5-style encryptor for 16-bit blocks: 8-bit half-words, fixed key table.
// A start/done handshake runs a four-state FSM: IDLE, ROUND_A, ROUND_B, DONE.
module rc5_enc_16bit_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        enc_start,
    input  logic [15:0] p,
    output logic [15:0] c,
    output logic        enc_done
);

    localparam logic [7:0] S0 = 8'h20;
    localparam logic [7:0] S1 = 8'h10;
    localparam logic [7:0] S2 = 8'hFF;
    localparam logic [7:0] S3 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ROUND_A,
        ROUND_B,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_reg;
    logic [7:0]  a_next;
    logic [7:0]  b_reg;
    logic [7:0]  b_next;
    logic [15:0] c_reg;
    logic [15:0] c_next;
    logic        done_reg;
    logic        done_next;

    logic [7:0]  round_a;
    logic [7:0]  round_b;

    // Rotate amount is taken from the low three bits only.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] wide;
        wide = {x, x} << n;
        return wide[15:8];
    endfunction

    // The B half of the round uses the already-updated A held in a_reg.
    always_comb begin
        round_a = rotl8(a_reg ^ b_reg, b_reg[2:0]) + S2;
        round_b = rotl8(b_reg ^ a_reg, a_reg[2:0]) + S3;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            a_reg    <= a_next;
            b_reg    <= b_next;
            c_reg    <= c_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        done_next  = done_reg;

        case (state)
            IDLE: begin
                done_next = 1'b0;
                if (enc_start) begin
                    a_next     = p[15:8] + S0;
                    b_next     = p[7:0] + S1;
                    state_next = ROUND_A;
                end
            end
            ROUND_A: begin
                a_next     = round_a;
                state_next = ROUND_B;
            end
            ROUND_B: begin
                b_next     = round_b;
                c_next     = {a_reg, round_b};
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (!enc_start) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                done_next  = 1'b0;
            end
        endcase
    end

    assign c        = c_reg;
    assign enc_done = done_reg;

endmodule

// File: tb/tb_rc5_enc_16bit_core.sv
// Randomized self-checking bench for rc5_enc_16bit_core against an arithmetic reference model.
module tb_rc5_enc_16bit_core;

    logic        clock;
    logic        reset;
    logic        enc_start;
    logic [15:0] p;
    logic [15:0] c;
    logic        enc_done;

    int unsigned pass_cnt;
    int unsigned check_cnt;

    rc5_enc_16bit_core dut (
        .clock    (clock),
        .reset    (reset),
        .enc_start(enc_start),
        .p        (p),
        .c        (c),
        .enc_done (enc_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int rol(input int x, input int n);
        int m;
        m = n % 8;
        return ((x << m) | (x >> (8 - m))) % 256;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] pt);
        int a;
        int b;
        a = (int'(pt) / 256 + 32) % 256;
        b = (int'(pt) % 256 + 16) % 256;
        a = (rol(a ^ b, b) + 255) % 256;
        b = (rol(b ^ a, a) + 255) % 256;
        return 16'(a * 256 + b);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start from IDLE, optionally scramble p after capture, wait for done, check result, then drop start.
    task automatic encrypt(input string tag, input logic [15:0] pt, input bit scramble);
        logic [15:0] c_before;
        logic [15:0] expect_c;
        int          k;
        expect_c  = model(pt);
        c_before  = c;
        p         = pt;
        enc_start = 1'b1;
        tick();
        k = 1;
        check({tag, "_c_held_a"}, c, c_before);
        check({tag, "_busy_a"}, 16'(enc_done), 16'd0);
        enc_start = 1'b0;
        if (scramble) p = 16'($urandom);
        while (!enc_done && k < 8) begin
            tick();
            k++;
        end
        check({tag, "_done"}, 16'(enc_done), 16'd1);
        check({tag, "_lat_ok"}, 16'(k <= 4), 16'd1);
        check({tag, "_c"}, c, expect_c);
        tick();
        check({tag, "_done_fall"}, 16'(enc_done), 16'd0);
        check({tag, "_c_kept"}, c, expect_c);
    endtask

    initial begin
        int k;
        pass_cnt  = 0;
        check_cnt = 0;
        reset     = 1'b0;
        enc_start = 1'b1;
        p         = 16'hFFFF;
        #1;
        check("rst_c", c, 16'h0000);
        check("rst_done", 16'(enc_done), 16'd0);
        tick();
        tick();
        reset = 1'b1;

        // Start held through reset release.
        k = 0;
        while (!enc_done && k < 8) begin
            tick();
            k++;
        end
        check("rel_lat_ok", 16'(k <= 4), 16'd1);
        check("rel_c", c, 16'h0703);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel_hold_done", 16'(enc_done), 16'd1);
            check("rel_hold_c", c, 16'h0703);
        end
        enc_start = 1'b0;
        tick();
        check("rel_done_fall", 16'(enc_done), 16'd0);
        check("rel_c_kept", c, 16'h0703);

        encrypt("ff00", 16'hFF00, 1'b0);
        encrypt("00ff", 16'h00FF, 1'b0);
        encrypt("0000", 16'h0000, 1'b0);
        encrypt("aaaa", 16'hAAAA, 1'b0);
        encrypt("5555", 16'h5555, 1'b1);

        // p changed two cycles after capture, start held throughout.
        p         = 16'hFFFF;
        enc_start = 1'b1;
        tick();
        tick();
        p = 16'h0000;
        k = 2;
        while (!enc_done && k < 8) begin
            tick();
            k++;
        end
        check("late_p_c", c, 16'h0703);
        tick();
        tick();
        check("late_p_hold_done", 16'(enc_done), 16'd1);
        check("late_p_hold_c", c, 16'h0703);
        enc_start = 1'b0;
        tick();
        check("late_p_fall", 16'(enc_done), 16'd0);

        // Reset pulse while in ROUND_A aborts immediately.
        p         = 16'h1234;
        enc_start = 1'b1;
        tick();
        enc_start = 1'b0;
        reset     = 1'b0;
        #1;
        check("abort_c", c, 16'h0000);
        check("abort_done", 16'(enc_done), 16'd0);
        tick();
        tick();
        check("abort_stay_done", 16'(enc_done), 16'd0);
        reset = 1'b1;
        tick();
        encrypt("after_abort", 16'h1234, 1'b0);

        for (int i = 0; i < 24; i++) begin
            encrypt("rand", 16'($urandom), 1'(i % 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
